bpi_cmd_sequencer: RTL

- Upstream driver for bpi_interface: turns one high-level flash request (read, program, erase, lock/unlock, status) into the required P30-style BPI command-cycle sequence.
- Issues sequence steps as single OP/EXECUTE transactions and waits on BUSY/LOAD_DATA between steps.
- Polls the flash status register for program and erase, then returns the flash to read-array mode.
- Reports read data, final status byte and error/timeout flags to the controlling logic (JTAG/user register side).

---
 rtl/bpi_cmd_sequencer.sv | 242 ++++++++++++++++++++++++
 1 files changed

// File: rtl/bpi_cmd_sequencer.sv
// Expands one high-level flash request into the P30-style BPI command-cycle
// sequence, polls status for program/erase and reports the outcome.
module bpi_cmd_sequencer #(
  parameter logic [1:0]  OP_WRITE = 2'd1,
  parameter logic [1:0]  OP_READ  = 2'd2,
  parameter int          POLL_GAP = 16,
  parameter logic [23:0] POLL_MAX = 24'd4000000
) (
  input  logic        CLK,
  input  logic        RST_B,
  input  logic        CMD_VALID,
  input  logic [2:0]  CMD_CODE,
  input  logic [22:0] CMD_ADDR,
  input  logic [15:0] CMD_DATA,
  output logic        CMD_READY,
  output logic        RSP_VALID,
  output logic [15:0] RSP_DATA,
  output logic [7:0]  RSP_STATUS,
  output logic        RSP_ERR,
  output logic        RSP_TMO,
  output logic [22:0] BPI_ADDR,
  output logic [15:0] BPI_DATA,
  output logic [1:0]  BPI_OP,
  output logic        BPI_EXECUTE,
  input  logic [15:0] BPI_DATA_IN,
  input  logic        BPI_LOAD_DATA,
  input  logic        BPI_BUSY
);

  localparam logic [2:0] C_READ   = 3'd0;
  localparam logic [2:0] C_PROG   = 3'd1;
  localparam logic [2:0] C_ERASE  = 3'd2;
  localparam logic [2:0] C_UNLOCK = 3'd3;
  localparam logic [2:0] C_LOCK   = 3'd4;
  localparam logic [2:0] C_STATUS = 3'd5;
  localparam logic [2:0] STEP_POLL = 3'd4;
  localparam logic [2:0] STEP_EXIT = 3'd5;
  localparam logic [7:0] GAP_LAST  = 8'(POLL_GAP - 1);

  typedef enum logic [2:0] {IDLE, ISSUE, SETTLE, WAIT, GAP, RESP} state_t;

  state_t      state, state_nx;
  logic [2:0]  step_q, step_nx;
  logic        got_q, got_nx;
  logic [7:0]  gap_q, gap_nx;
  logic [23:0] poll_q, poll_nx, poll_inc;
  logic [15:0] rsp_data_q, data_nx;
  logic [7:0]  rsp_status_q, status_nx;
  logic        rsp_err_q, err_nx;
  logic        rsp_tmo_q, tmo_nx;
  logic [2:0]  code_q;
  logic [22:0] addr_q;
  logic [15:0] data_q;
  logic [15:0] cap_q;
  logic [15:0] rd_word;
  logic        accept, cap_en, done, step_rd, active;

  function automatic logic step_is_read(input logic [2:0] code, input logic [2:0] step);
    return ((code == C_READ) && (step == 3'd1)) ||
           (((code == C_PROG) || (code == C_ERASE)) && (step == STEP_POLL)) ||
           ((code == C_STATUS) && (step == 3'd1));
  endfunction

  function automatic logic is_poll(input logic [2:0] code, input logic [2:0] step);
    return ((code == C_PROG) || (code == C_ERASE)) && (step == STEP_POLL);
  endfunction

  function automatic logic [2:0] last_step(input logic [2:0] code);
    case (code)
      C_PROG, C_ERASE: return STEP_EXIT;
      C_STATUS:        return 3'd2;
      default:         return 3'd1;
    endcase
  endfunction

  // Command bytes ride on the low byte; only the PROGRAM data word is full width.
  function automatic logic [15:0] step_word(input logic [2:0] code, input logic [2:0] step,
                                            input logic [15:0] wdata);
    logic [7:0] b;
    b = 8'h00;
    case (code)
      C_READ: if (step == 3'd0) b = 8'hFF;
      C_PROG, C_ERASE:
        case (step)
          3'd0:    b = 8'h50;
          3'd1:    b = (code == C_PROG) ? 8'h40 : 8'h20;
          3'd2:    b = 8'hD0;
          3'd3:    b = 8'h70;
          3'd5:    b = 8'hFF;
          default: b = 8'h00;
        endcase
      C_UNLOCK: b = (step == 3'd0) ? 8'h60 : 8'hD0;
      C_LOCK:   b = (step == 3'd0) ? 8'h60 : 8'h01;
      C_STATUS: b = (step == 3'd0) ? 8'h70 : 8'hFF;
      default:  b = 8'h00;
    endcase
    if ((code == C_PROG) && (step == 3'd2)) return wdata;
    return {8'h00, b};
  endfunction

  assign step_rd     = step_is_read(code_q, step_q);
  assign active      = (state == ISSUE) || (state == SETTLE) || (state == WAIT) || (state == GAP);
  assign BPI_ADDR    = active ? addr_q : '0;
  assign BPI_OP      = active ? (step_rd ? OP_READ : OP_WRITE) : 2'd0;
  assign BPI_DATA    = (active && !step_rd) ? step_word(code_q, step_q, data_q) : '0;
  assign BPI_EXECUTE = (state == ISSUE) && !BPI_BUSY;
  assign CMD_READY   = (state == IDLE);
  assign RSP_VALID   = (state == RESP);
  assign RSP_DATA    = rsp_data_q;
  assign RSP_STATUS  = rsp_status_q;
  assign RSP_ERR     = rsp_err_q;
  assign RSP_TMO     = rsp_tmo_q;

  always_comb begin
    state_nx  = state;
    step_nx   = step_q;
    got_nx    = got_q;
    gap_nx    = gap_q;
    poll_nx   = poll_q;
    data_nx   = rsp_data_q;
    status_nx = rsp_status_q;
    err_nx    = rsp_err_q;
    tmo_nx    = rsp_tmo_q;
    accept    = 1'b0;
    cap_en    = 1'b0;
    done      = 1'b0;
    poll_inc  = (poll_q == '1) ? poll_q : poll_q + 24'd1;
    rd_word   = got_q ? cap_q : BPI_DATA_IN;
    case (state)
      IDLE:
        if (CMD_VALID) begin
          accept    = 1'b1;
          step_nx   = 3'd0;
          got_nx    = 1'b0;
          gap_nx    = 8'd0;
          poll_nx   = 24'd0;
          data_nx   = 16'd0;
          status_nx = 8'd0;
          tmo_nx    = 1'b0;
          if (CMD_CODE > C_STATUS) begin
            err_nx   = 1'b1;
            state_nx = RESP;
          end else begin
            err_nx   = 1'b0;
            state_nx = ISSUE;
          end
        end
      ISSUE:
        if (!BPI_BUSY) begin
          got_nx   = 1'b0;
          state_nx = SETTLE;
        end
      SETTLE: state_nx = WAIT;
      WAIT: begin
        // A read completes only after its data strobe and the bus going idle.
        if (step_rd) begin
          if (BPI_LOAD_DATA && !got_q) begin
            got_nx = 1'b1;
            cap_en = 1'b1;
          end
          done = (got_q || BPI_LOAD_DATA) && !BPI_BUSY;
        end else begin
          done = !BPI_BUSY;
        end
        if (done) begin
          if (is_poll(code_q, step_q)) begin
            status_nx = rd_word[7:0];
            poll_nx   = poll_inc;
            if (rd_word[7]) begin
              err_nx   = |(rd_word[7:0] & 8'h3A);
              step_nx  = STEP_EXIT;
              state_nx = ISSUE;
            end else if (poll_inc >= POLL_MAX) begin
              tmo_nx   = 1'b1;
              err_nx   = 1'b1;
              step_nx  = STEP_EXIT;
              state_nx = ISSUE;
            end else begin
              gap_nx   = 8'd0;
              state_nx = GAP;
            end
          end else begin
            if (step_rd) begin
              if (code_q == C_STATUS) status_nx = rd_word[7:0];
              else                    data_nx   = rd_word;
            end
            if (step_q == last_step(code_q)) begin
              state_nx = RESP;
            end else begin
              step_nx  = step_q + 3'd1;
              state_nx = ISSUE;
            end
          end
        end
      end
      GAP:
        if (gap_q == GAP_LAST) begin
          gap_nx   = 8'd0;
          state_nx = ISSUE;
        end else begin
          gap_nx = gap_q + 8'd1;
        end
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_B) begin
    if (!RST_B) begin
      state        <= IDLE;
      step_q       <= 3'd0;
      got_q        <= 1'b0;
      gap_q        <= 8'd0;
      poll_q       <= 24'd0;
      rsp_data_q   <= 16'd0;
      rsp_status_q <= 8'd0;
      rsp_err_q    <= 1'b0;
      rsp_tmo_q    <= 1'b0;
    end else begin
      state        <= state_nx;
      step_q       <= step_nx;
      got_q        <= got_nx;
      gap_q        <= gap_nx;
      poll_q       <= poll_nx;
      rsp_data_q   <= data_nx;
      rsp_status_q <= status_nx;
      rsp_err_q    <= err_nx;
      rsp_tmo_q    <= tmo_nx;
    end
  end

  // Request fields and captured read word are plain data registers.
  always_ff @(posedge CLK) begin
    if (accept) begin
      code_q <= CMD_CODE;
      addr_q <= CMD_ADDR;
      data_q <= CMD_DATA;
    end
    if (cap_en) cap_q <= BPI_DATA_IN;
  end

endmodule
